// File: rtl/lsu_rmw.sv
// Load/store sequencer: turns core byte/half/word requests into word accesses
// on a one-cycle-latency synchronous RAM, with read-modify-write for sub-word stores.
module lsu_rmw (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  load_type,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall,
    output logic [13:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_LDX   = 3'd3,
        S_WR    = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Fields captured at accept so later input changes cannot disturb the op
    logic          write_q;
    logic [2:0]    ltype_q;
    logic [1:0]    stype_q;
    logic [1:0]    off_q;
    logic [DW-1:0] wdata_q;

    // Next values of the registered outputs
    logic [DW-1:0] rdata_d;
    logic          done_d;
    logic          err_d;
    logic [AW-1:0] mem_addr_d;
    logic          mem_we_d;
    logic [DW-1:0] mem_wdata_d;

    logic          accept;
    logic          req_err;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [DW-1:0] load_ext;
    logic [DW-1:0] merged;

    // Address bits above the RAM's word index are intentionally dropped
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:16];

    assign accept = (state == S_IDLE) && req_valid && !done;
    assign stall  = req_valid && !done;

    // Misalignment / illegal-type detection on the live request
    always_comb begin
        req_err = 1'b0;
        if (req_write) begin
            case (store_type)
                ST_SB:   req_err = 1'b0;
                ST_SH:   req_err = addr[0];
                ST_SW:   req_err = |addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (load_type)
                LT_LB, LT_LBU: req_err = 1'b0;
                LT_LH, LT_LHU: req_err = addr[0];
                LT_LW:         req_err = |addr[1:0];
                default:       req_err = 1'b1;
            endcase
        end
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
        half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (ltype_q)
            LT_LB:   load_ext = {{24{byte_lane[7]}}, byte_lane};
            LT_LH:   load_ext = {{16{half_lane[15]}}, half_lane};
            LT_LBU:  load_ext = {24'd0, byte_lane};
            LT_LHU:  load_ext = {16'd0, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Replace the addressed little-endian lane of the read word with store data
    always_comb begin
        merged = mem_rdata;
        if (stype_q == ST_SB) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && !req_err) begin
                    if (req_write && (store_type == ST_SW)) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD:    state_nxt = write_q ? S_MERGE : S_LDX;
            S_MERGE: state_nxt = S_WR;
            S_LDX:   state_nxt = S_IDLE;
            S_WR:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        rdata_d     = rdata;
        err_d       = err;
        done_d      = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        mem_addr_d = addr[15:2];
                        if (req_write && (store_type == ST_SW)) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = wdata;
                        end
                    end
                end
            end
            S_MERGE: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = merged;
            end
            S_LDX: begin
                rdata_d = load_ext;
                err_d   = 1'b0;
                done_d  = 1'b1;
            end
            S_WR: begin
                err_d  = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            rdata     <= rdata_d;
            done      <= done_d;
            err       <= err_d;
            mem_addr  <= mem_addr_d;
            mem_we    <= mem_we_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Request capture at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            ltype_q <= '0;
            stype_q <= '0;
            off_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            ltype_q <= load_type;
            stype_q <= store_type;
            off_q   <= addr[1:0];
            wdata_q <= wdata;
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw with a behavioural one-cycle-latency RAM.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        stall;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:16383];

    typedef struct {
        int          id;
        int          issue;
        logic [31:0] rd;
        bit          chk_rd;
        bit          e;
        int          lat;
        int          we_off;
        logic [13:0] maddr;
        logic [31:0] mwd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   we_cnt = 0;

    lsu_rmw dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .load_type  (load_type),
        .store_type (store_type),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .err        (err),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM: read returns the pre-write contents
    always @(posedge clk) begin
        logic [31:0] rd_tmp;
        rd_tmp = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= rd_tmp;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares each write strobe and each done against the queued expectation
    always @(negedge clk) begin
        if (mem_we) begin
            if (q.size() == 0) begin
                chk("spurious_we", 32'(mem_we), 32'd0);
            end else begin
                we_cnt++;
                chk($sformatf("op%0d_we_cycle", q[0].id), 32'(cyc - q[0].issue), 32'(q[0].we_off));
                chk($sformatf("op%0d_we_addr", q[0].id), 32'(mem_addr), 32'(q[0].maddr));
                chk($sformatf("op%0d_we_data", q[0].id), mem_wdata, q[0].mwd);
            end
        end
        if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.issue), 32'(e.lat));
                chk($sformatf("op%0d_err", e.id), 32'(err), 32'(e.e));
                if (e.chk_rd) chk($sformatf("op%0d_rdata", e.id), rdata, e.rd);
                chk($sformatf("op%0d_we_count", e.id), 32'(we_cnt), (e.we_off >= 0) ? 32'd1 : 32'd0);
                we_cnt = 0;
            end
        end
    end

    task automatic issue(input int id, input bit wr, input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit chk_rd, input bit e,
                         input int lat, input int we_off, input logic [31:0] mwd,
                         input bit chk_stall);
        exp_t ent;
        bit   got;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_write  = wr;
        load_type  = lt;
        store_type = st;
        addr       = a;
        wdata      = wd;
        ent.id = id; ent.issue = cyc; ent.rd = exp_rd; ent.chk_rd = chk_rd; ent.e = e;
        ent.lat = lat; ent.we_off = we_off; ent.maddr = a[15:2]; ent.mwd = mwd;
        q.push_back(ent);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (chk_stall) chk($sformatf("op%0d_stall_c%0d", id, k), 32'(stall), (k < lat) ? 32'd1 : 32'd0);
            if (done) got = 1'b1;
            // Scramble live inputs once the request has been taken
            if (k >= 1) begin
                addr  = a ^ 32'h0000_0F0C;
                wdata = ~wd;
            end
        end
        if (!got) begin
            chk($sformatf("op%0d_timeout", id), 32'd0, 32'd1);
            q.delete();
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; load_type = 3'b010;
        store_type = 2'b10; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_we", 32'(mem_we), 32'd0);
        chk("reset_maddr", 32'(mem_addr), 32'd0);
        chk("reset_mwdata", mem_wdata, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // sw then lw
        issue(1, 1'b1, 3'b010, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2, 1, 32'hDEADBEEF, 1'b0);
        chk("mem_after_sw", mem[14'h040], 32'hDEADBEEF);
        issue(2, 1'b0, 3'b010, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3, -1, 32'h0, 1'b0);

        // sb into the top byte
        mem[14'h040] = 32'h11223344;
        issue(3, 1'b1, 3'b010, 2'b00, 32'h103, 32'h000000A5, 32'h0, 1'b0, 1'b0, 4, 3, 32'hA5223344, 1'b0);
        chk("mem_after_sb", mem[14'h040], 32'hA5223344);

        // sub-word loads with sign/zero extension
        mem[14'h060] = 32'h8081F27F;
        issue(4, 1'b0, 3'b000, 2'b10, 32'h180, 32'h0, 32'h0000007F, 1'b1, 1'b0, 3, -1, 32'h0, 1'b0);
        issue(5, 1'b0, 3'b000, 2'b10, 32'h181, 32'h0, 32'hFFFFFFF2, 1'b1, 1'b0, 3, -1, 32'h0, 1'b0);
        issue(6, 1'b0, 3'b011, 2'b10, 32'h183, 32'h0, 32'h00000080, 1'b1, 1'b0, 3, -1, 32'h0, 1'b0);
        issue(7, 1'b0, 3'b001, 2'b10, 32'h182, 32'h0, 32'hFFFF8081, 1'b1, 1'b0, 3, -1, 32'h0, 1'b0);
        issue(8, 1'b0, 3'b100, 2'b10, 32'h180, 32'h0, 32'h0000F27F, 1'b1, 1'b0, 3, -1, 32'h0, 1'b0);

        // error cases: no memory access, done one cycle after accept
        issue(9,  1'b0, 3'b010, 2'b10, 32'h102, 32'h0, 32'h0, 1'b0, 1'b1, 1, -1, 32'h0, 1'b0);
        issue(10, 1'b1, 3'b010, 2'b11, 32'h100, 32'h12345678, 32'h0, 1'b0, 1'b1, 1, -1, 32'h0, 1'b0);
        issue(11, 1'b0, 3'b101, 2'b10, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 1, -1, 32'h0, 1'b0);
        issue(12, 1'b1, 3'b010, 2'b01, 32'h201, 32'hBEEF, 32'h0, 1'b0, 1'b1, 1, -1, 32'h0, 1'b0);
        chk("mem_after_errors", mem[14'h040], 32'hA5223344);

        // sh into the upper half, with stall profile
        mem[14'h080] = 32'h11223344;
        issue(13, 1'b1, 3'b010, 2'b01, 32'h202, 32'h0000BEEF, 32'h0, 1'b0, 1'b0, 4, 3, 32'hBEEF3344, 1'b1);
        chk("mem_after_sh", mem[14'h080], 32'hBEEF3344);

        // reset during MERGE of an sb: aborted, no write, no done
        mem[14'h0C0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; store_type = 2'b00; load_type = 3'b010;
        addr = 32'h300; wdata = 32'h00000055;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_maddr", 32'(mem_addr), 32'd0);
        chk("abort_mwdata", mem_wdata, 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_mem_unchanged", mem[14'h0C0], 32'hCAFEF00D);

        // fresh load after the abort
        issue(14, 1'b0, 3'b010, 2'b10, 32'h100, 32'h0, 32'hA5223344, 1'b1, 1'b0, 3, -1, 32'h0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store sequencer between the core's memory stage and the word-wide data memory. It converts core load/store requests into word accesses on a synchronous-read RAM with one cycle of read latency and a single write enable. Byte and halfword stores are done as read-modify-write. Byte and halfword loads are extracted by address offset and then sign- or zero-extended. The block stalls the core until each access completes and flags misaligned or illegal requests without touching memory.

## Interface
No parameters.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core has a memory op; held stable until done
- req_write  in  1  1 = store, 0 = load
- load_type  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; 101–111 illegal
- store_type  in  2  00 sb, 01 sh, 10 sw; 11 illegal
- addr  in  32  byte address
- wdata  in  32  store data; sb uses [7:0], sh uses [15:0]
- rdata  out  32  extended load result; valid while done=1
- done  out  1  one-cycle pulse: op complete
- err  out  1  valid with done: misaligned or illegal op, no memory access made
- stall  out  1  combinational req_valid & ~done
- mem_addr  out  14  word index = addr[15:2] (upper bits ignored; wraps)
- mem_we  out  1  word write enable
- mem_wdata  out  32  write word
- mem_rdata  in  32  RAM read data; valid the cycle after mem_addr is presented

## Operation
- States: IDLE, RD, MERGE, LDX, WR.
- IDLE
  - Accepts when req_valid=1 and done=0. req_valid is ignored in the cycle done=1.
  - On accept, latches addr, wdata, type and offset=addr[1:0].
- Error check (evaluated at accept):
  - lh/lhu/sh with offset[0]=1
  - lw/sw with offset≠0
  - any illegal type code
  - On error: go to IDLE, next cycle done=1 and err=1. mem_we stays 0.
- Load path: IDLE→RD→LDX→IDLE.
  - RD: mem_addr presented.
  - LDX: mem_rdata sampled.
    - Byte lane = mem_rdata[8*offset+7 : 8*offset].
    - Half lane = mem_rdata[16*offset[1]+15 : 16*offset[1]].
    - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
    - Result registered into rdata.
- sw: IDLE→WR→IDLE. WR drives mem_we=1 with mem_wdata=wdata.
- sb/sh: IDLE→RD→MERGE→WR→IDLE.
  - MERGE: registers mem_rdata with the addressed little-endian lane replaced by wdata[7:0] or wdata[15:0].
  - WR writes the merged word.
- done asserts in the cycle after the final state, with the state back in IDLE.
- rdata and err hold their values until the next done. err=0 on successful ops.

## Timing
- Reset values: state IDLE; rdata=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- All outputs except stall are registered. mem_addr and mem_wdata are stable from RD (or WR) through WR.
- Latency from accept cycle C0:
  - error: done at C1
  - sw: mem_we at C1, done at C2
  - load: mem_addr at C1, data at C2, done at C3
  - sb/sh: read at C1, merge at C2, mem_we at C3, done at C4
- mem_we is high for exactly one cycle per store, and only in WR.
- Back-to-back requests: the earliest next accept is the cycle after done.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values.
  - An RMW reset before WR performs no write.
  - No done is issued for the aborted op.
- Input changes while busy are ignored because all fields were latched at accept.

## Test plan
- sw then lw, addr=0x100, wdata=0xDEADBEEF:
  - store: mem_we one cycle at C1 with mem_addr=0x040; done at C2
  - load: done at C3 with rdata=0xDEADBEEF, err=0
- sb at addr=0x103, wdata=0x000000A5, word preloaded 0x11223344:
  - word becomes 0xA5223344
  - mem_we single pulse at C3; done at C4
- Loads from word 0x8081F27F:
  - lb@+0 → 0x0000007F
  - lb@+1 → 0xFFFFFFF2
  - lbu@+3 → 0x00000080
  - lh@+2 → 0xFFFF8081
  - lhu@+0 → 0x0000F27F
- Error cases:
  - lw at addr=0x102 → done at C1 with err=1, mem_we never high
  - store_type=11 → err=1
  - load_type=101 → err=1
- sh at addr=0x202, wdata=0xBEEF, word 0x11223344:
  - word becomes 0xBEEF3344
  - stall high C0–C3, low at C4
  - req_valid held through done not re-accepted
- rst asserted during MERGE of an sb:
  - no mem_we
  - outputs at reset values next cycle
  - memory word unchanged
  - a fresh lw afterwards completes normally
